// File: rtl/hamming_secded_codec.sv
// Pipelined Hamming SECDED encoder/decoder with valid/ready streaming on both sides
// and saturating counters of corrected and uncorrectable errors.
module hamming_secded_codec #(
    parameter int unsigned DATA_W = 11,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned R = (DATA_W <= 4)   ? 3 :
                                (DATA_W <= 11)  ? 4 :
                                (DATA_W <= 26)  ? 5 :
                                (DATA_W <= 57)  ? 6 :
                                (DATA_W <= 120) ? 7 :
                                (DATA_W <= 247) ? 8 :
                                (DATA_W <= 502) ? 9 : 10,
    localparam int unsigned CODE_W = DATA_W + R + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_data,
    output logic [R-1:0]      out_syndrome,
    output logic              out_single,
    output logic              out_double,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);
    // Hamming positions 1..PW; the overall parity bit sits above them
    localparam int unsigned PW = CODE_W - 1;

    typedef struct packed {
        logic [CODE_W-1:0] data;
        logic [R-1:0]      syn;
        logic              single;
        logic              double;
    } stage_t;

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        int unsigned j;
        c = '0;
        j = 0;
        for (int unsigned p = 1; p <= PW; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        end
        for (int unsigned k = 0; k < R; k++) begin
            for (int unsigned p = 1; p <= PW; p++) begin
                if (p[k] && ((p & (p - 1)) != 0)) c[(1 << k) - 1] ^= c[p-1];
            end
        end
        c[CODE_W-1] = ^c[CODE_W-2:0];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int unsigned j;
        d = '0;
        j = 0;
        for (int unsigned p = 1; p <= PW; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[j] = c[p-1];
                j++;
            end
        end
        return d;
    endfunction

    logic [R-1:0]      syn;
    logic              par;
    logic [CODE_W-1:0] fixed;
    stage_t            res;
    stage_t            s1_q, s1_d, s2_q, s2_d;
    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic              en1, en2, xfer;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d, cnt_uncorr_q, cnt_uncorr_d;

    always_comb begin
        syn = '0;
        for (int unsigned p = 1; p <= PW; p++) begin
            if (in_data[p-1]) syn ^= p[R-1:0];
        end
        par   = ^in_data;
        fixed = in_data;
        // Only a single error (odd parity, in-range syndrome) flips a bit
        for (int unsigned p = 1; p <= PW; p++) begin
            if (par && (syn == p[R-1:0])) fixed[p-1] = ~fixed[p-1];
        end
        res = '0;
        if (in_mode) begin
            res.data   = CODE_W'(extract(fixed));
            res.syn    = syn;
            res.single = par && (32'(syn) <= PW);
            res.double = (par && (32'(syn) > PW)) || (!par && (syn != '0));
        end else begin
            res.data = encode(in_data[DATA_W-1:0]);
        end
    end

    assign en2      = !s2_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1;
    assign xfer     = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (en1) begin
            s1_valid_d = in_valid;
            s1_d       = res;
        end
        if (en2) begin
            s2_valid_d = s1_valid_q;
            s2_d       = s1_q;
        end
    end

    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (clr_cnt) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (xfer) begin
            if (s2_q.single && (cnt_corr_q != '1)) cnt_corr_d = cnt_corr_q + CNT_W'(1);
            if (s2_q.double && (cnt_uncorr_q != '1)) cnt_uncorr_d = cnt_uncorr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s2_valid_q   <= 1'b0;
            s2_q         <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            s2_valid_q   <= s2_valid_d;
            s2_q         <= s2_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = s2_q.data;
    assign out_syndrome = s2_q.syn;
    assign out_single   = s2_q.single;
    assign out_double   = s2_q.double;
    assign cnt_corr     = cnt_corr_q;
    assign cnt_uncorr   = cnt_uncorr_q;

endmodule
